// File: rtl/prog_loader.sv
// Framed byte-stream loader for the 32 x 16 program RAM: assembles hi/lo byte pairs
// into words, writes them sequentially and releases the core only after a good checksum.
module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              load_ok,
  output logic              load_err,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [7:0] HEADER  = 8'hA5;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_CSUM,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          xor_q, xor_d;
  logic                hold_q, hold_d;
  logic                ok_q, ok_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic                xfer;

  assign in_ready = (state_q != S_ERR);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    xor_d     = xor_q;
    hold_d    = hold_q;
    ok_d      = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (abort) begin
      state_d = S_IDLE;
      if (state_q != S_IDLE) hold_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (xfer && in_data == HEADER) begin
            state_d = S_LEN;
            hold_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            if (in_data == 8'h00 || in_data > DEPTH_B) begin
              state_d = S_ERR;
            end else begin
              n_d     = in_data[ADDR_W:0];
              xor_d   = '0;
              state_d = S_HI;
            end
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_d    = in_data;
            xor_d   = xor_q ^ in_data;
            state_d = S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            xor_d     = xor_q ^ in_data;
            wr_en_d   = 1'b1;
            // word_cnt doubles as the write address: both restart at 0 on the header
            wr_addr_d = cnt_q[ADDR_W-1:0];
            wr_data_d = WORD_W'({hi_q, in_data});
            cnt_d     = cnt_q + 1'b1;
            state_d   = (cnt_d == n_q) ? S_CSUM : S_HI;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (in_data == xor_q) begin
              state_d = S_IDLE;
              ok_d    = 1'b1;
              hold_d  = 1'b0;
            end else begin
              state_d = S_ERR;
            end
          end
        end
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      xor_q     <= '0;
      hold_q    <= 1'b1;
      ok_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      xor_q     <= xor_d;
      hold_q    <= hold_d;
      ok_q      <= ok_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != S_IDLE);
  assign load_ok  = ok_q;
  assign load_err = (state_q == S_ERR);
  assign cpu_hold = hold_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes/results,
// a negedge monitor pops and compares whenever the DUT emits them.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        abort = 1'b0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy, load_ok, load_err, cpu_hold;
  logic [5:0]  word_cnt;

  prog_loader #(.ADDR_W(5), .DEPTH(32), .WORD_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .load_ok(load_ok), .load_err(load_err), .cpu_hold(cpu_hold), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t wq[$];
  int  rq[$];   // 1 = load_ok, 2 = load_err
  int  tests = 0;
  int  fails = 0;
  logic [15:0] words [32];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_unexpected: got write addr %0d data 0x%0h expected none", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", int'(wr_addr), e.addr);
          chk("wr_data", int'(wr_data), e.data);
        end
      end
      if (load_ok || load_err) begin
        int got;
        got = (load_ok && load_err) ? 3 : (load_ok ? 1 : 2);
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL result_unexpected: got %0d expected none", got);
        end else begin
          chk("result_kind", got, rq.pop_front());
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin tick(); t++; end
    if (t >= 20) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1");
    end
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_frame(input int n, input logic [7:0] csum, input bit good, input int gap);
    for (int i = 0; i < n; i++) wq.push_back('{addr: i, data: int'(words[i])});
    rq.push_back(good ? 1 : 2);
    send_byte(8'hA5, gap);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][15:8], gap);
      send_byte(words[i][7:0], gap);
    end
    send_byte(csum, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_load_ok"}, int'(load_ok), 0);
    chk({tag, "_load_err"}, int'(load_err), 0);
    chk({tag, "_cpu_hold"}, int'(cpu_hold), 1);
    chk({tag, "_word_cnt"}, int'(word_cnt), 0);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_vals("rst");
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    tick();

    // Good load, checksum 12^34^AB^CD = 40
    words[0] = 16'h1234; words[1] = 16'hABCD;
    send_frame(2, 8'h40, 1'b1, 0);
    chk("good_load_ok", int'(load_ok), 1);
    chk("good_hold", int'(cpu_hold), 0);
    chk("good_cnt", int'(word_cnt), 2);
    chk("good_busy", int'(busy), 0);
    tick();
    chk("good_ok_pulse", int'(load_ok), 0);

    // Full depth, words 0..31: XOR of 0..31 = 00
    for (int i = 0; i < 32; i++) words[i] = 16'(i);
    send_frame(32, 8'h00, 1'b1, 0);
    chk("full_load_ok", int'(load_ok), 1);
    chk("full_cnt", int'(word_cnt), 32);
    chk("full_hold", int'(cpu_hold), 0);
    tick();

    // Bad lengths 00 and 21
    rq.push_back(2);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    chk("len0_err", int'(load_err), 1);
    chk("len0_ready", int'(in_ready), 0);
    chk("len0_hold", int'(cpu_hold), 1);
    tick();
    chk("len0_err_pulse", int'(load_err), 0);
    rq.push_back(2);
    send_byte(8'hA5, 0);
    send_byte(8'h21, 0);
    chk("len21_err", int'(load_err), 1);
    chk("len21_cnt", int'(word_cnt), 0);
    tick();

    // Bad checksum: FF00 written, then rejected
    words[0] = 16'hFF00;
    send_frame(1, 8'h00, 1'b0, 0);
    chk("badcs_err", int'(load_err), 1);
    chk("badcs_hold", int'(cpu_hold), 1);
    tick();
    chk("badcs_hold2", int'(cpu_hold), 1);
    words[0] = 16'h1234; words[1] = 16'hABCD;
    send_frame(2, 8'h40, 1'b1, 0);
    chk("recover_ok", int'(load_ok), 1);
    chk("recover_hold", int'(cpu_hold), 0);
    tick();

    // Abort with LO byte of word 1, N=3
    wq.push_back('{addr: 0, data: 16'h1122});
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    in_valid = 1'b1; in_data = 8'h44; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_ok", int'(load_ok), 0);
    chk("abort_err", int'(load_err), 0);
    chk("abort_hold", int'(cpu_hold), 1);
    chk("abort_cnt", int'(word_cnt), 1);
    tick();

    // Reset mid-frame
    wq.push_back('{addr: 0, data: 16'h5566});
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    send_byte(8'h77, 0);
    in_valid = 1'b1; in_data = 8'h88; rst = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_reset_vals("midrst");
    rst = 1'b0;
    tick();

    // Noise bytes and gapped stream
    send_byte(8'h00, 1);
    send_byte(8'h5A, 1);
    chk("noise_busy", int'(busy), 0);
    send_frame(2, 8'h40, 1'b1, 1);
    chk("gap_load_ok", int'(load_ok), 1);
    chk("gap_hold", int'(cpu_hold), 0);
    chk("gap_cnt", int'(word_cnt), 2);

    repeat (5) tick();
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
